// File: rtl/sdram_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-port SDRAM round-robin arbiter:
//   - default address/data widths of the controller user interface
//   - FSM state encoding (plain 2-bit constants so older tools can read dumps)
//   - helper that builds the controller byte mask from sel/we
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Reads never carry a byte mask to the controller; writes pass sel through.
    function automatic logic [3:0] ctrl_mask_of(input logic [3:0] sel, input logic we);
        return sel & {4{we}};
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter_if
// Bundles both requester ports and the controller user-side handshake.
//   slave  : view of the arbiter (consumes requests, drives the controller)
//   master : view of the environment (requesters + controller model)
// Signals:
//   reqN_valid/we/sel/addr/wdata  request from port N, held until reqN_ack
//   reqN_ack/reqN_err             one-cycle completion, err = read timed out
//   rdata                         shared read data, valid with reqN_ack
//   ctrl_in_valid/rw/addr/wdata/mask, ctrl_busy, ctrl_out_valid, ctrl_rdata
//                                 controller user interface
//   grant_id, timeout_err         status
// -----------------------------------------------------------------------------
interface sdram_rr_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0_valid;
    logic              req0_we;
    logic [3:0]        req0_sel;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ack;
    logic              req0_err;

    logic              req1_valid;
    logic              req1_we;
    logic [3:0]        req1_sel;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ack;
    logic              req1_err;

    logic [DATA_W-1:0] rdata;

    logic              ctrl_in_valid;
    logic              ctrl_rw;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic [3:0]        ctrl_mask;
    logic              ctrl_busy;
    logic              ctrl_out_valid;
    logic [DATA_W-1:0] ctrl_rdata;

    logic              grant_id;
    logic              timeout_err;

    modport slave (
        input  req0_valid, req0_we, req0_sel, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_sel, req1_addr, req1_wdata,
        output req0_ack, req0_err, req1_ack, req1_err, rdata,
        output ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask,
        input  ctrl_busy, ctrl_out_valid, ctrl_rdata,
        output grant_id, timeout_err
    );

    modport master (
        output req0_valid, req0_we, req0_sel, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_sel, req1_addr, req1_wdata,
        input  req0_ack, req0_err, req1_ack, req1_err, rdata,
        input  ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_mask,
        output ctrl_busy, ctrl_out_valid, ctrl_rdata,
        input  grant_id, timeout_err
    );

endinterface

// File: rtl/sdram_rr_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-requester round-robin selector.
//   valid0_i, valid1_i : request pending on port 0 / 1
//   last_i             : port granted most recently
//   gnt_o              : winning port (meaningful only when any_o = 1)
//   any_o              : at least one request pending
// On a tie the port that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_i,
    output logic gnt_o,
    output logic any_o
);

    // Port 1 wins when it is alone, or when both request and port 0 went last.
    assign gnt_o = valid1_i & (~valid0_i | ~last_i);
    assign any_o = valid0_i | valid1_i;

endmodule

// File: rtl/sdram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter
// Two-port round-robin arbiter/sequencer in front of the SDRAM controller user
// interface. Port 0 is the CPU path, port 1 a DMA/prefetch engine. One access
// is outstanding at a time; the controller request is held stable while the
// controller is busy, and each access completes with a single-cycle ack.
// Reads are guarded by a watchdog that completes them with err after
// RD_TIMEOUT cycles in WAIT_RD.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset (shared with the controller)
//   bus  sdram_rr_arbiter_if.slave: both request ports, controller handshake,
//        shared rdata, grant_id and sticky timeout_err
// -----------------------------------------------------------------------------
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    sdram_rr_arbiter_if.slave   bus
);

    localparam int              TW          = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(RD_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmo_q, tmo_d;

    logic              pick_gnt;
    logic              pick_any;
    logic [TW-1:0]     timer_inc;
    logic [1:0]        port_ack;

    rr_pick2 u_pick (
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .last_i   (last_q),
        .gnt_o    (pick_gnt),
        .any_o    (pick_any)
    );

    assign timer_inc = timer_q + TW'(1);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        last_d  = last_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_gnt;
                    we_d    = pick_gnt ? bus.req1_we    : bus.req0_we;
                    sel_d   = pick_gnt ? bus.req1_sel   : bus.req0_sel;
                    addr_d  = pick_gnt ? bus.req1_addr  : bus.req0_addr;
                    wdata_d = pick_gnt ? bus.req1_wdata : bus.req0_wdata;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.ctrl_busy) begin
                    if (we_q) begin
                        state_d = ST_RESP;
                    end else begin
                        timer_d = '0;
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                timer_d = timer_inc;
                // Data arriving on the timeout cycle still counts as success.
                if (bus.ctrl_out_valid) begin
                    rdata_d = bus.ctrl_rdata;
                    state_d = ST_RESP;
                end else if (timer_inc == TIMEOUT_VAL) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;    // so port 0 wins the first tie
            timer_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Ack goes only to the port whose request was latched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign port_ack[gi] = (state_q == ST_RESP) && (id_q == 1'(gi));
    end

    assign bus.req0_ack      = port_ack[0];
    assign bus.req1_ack      = port_ack[1];
    assign bus.req0_err      = port_ack[0] & err_q;
    assign bus.req1_err      = port_ack[1] & err_q;
    assign bus.rdata         = rdata_q;

    assign bus.ctrl_in_valid = (state_q == ST_ISSUE);
    assign bus.ctrl_rw       = (state_q == ST_ISSUE) & we_q;
    assign bus.ctrl_addr     = addr_q;
    assign bus.ctrl_wdata    = wdata_q;
    assign bus.ctrl_mask     = ctrl_mask_of(sel_q, we_q);

    assign bus.grant_id      = id_q;
    assign bus.timeout_err   = tmo_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_rr_arbiter
// Directed bench for sdram_rr_arbiter (RD_TIMEOUT = 8). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sdram_rr_arbiter;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 32;
    localparam int RD_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    sdram_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_rr_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [3:0] sel,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_sel = sel;
            bus.req0_addr  = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_sel = sel;
            bus.req1_addr  = a; bus.req1_wdata = d;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack0"},  bus.req0_ack, 0);
        chk({tag, "_ack1"},  bus.req1_ack, 0);
        chk({tag, "_err0"},  bus.req0_err, 0);
        chk({tag, "_err1"},  bus.req1_err, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_civ"},   bus.ctrl_in_valid, 0);
        chk({tag, "_rw"},    bus.ctrl_rw, 0);
        chk({tag, "_addr"},  bus.ctrl_addr, 0);
        chk({tag, "_wdata"}, bus.ctrl_wdata, 0);
        chk({tag, "_mask"},  bus.ctrl_mask, 0);
        chk({tag, "_gid"},   bus.grant_id, 0);
        chk({tag, "_tmo"},   bus.timeout_err, 0);
    endtask

    int                cnt0, cnt1, n_acks, last_ack_c, exp_port;
    logic [ADDR_W-1:0] a0, a1;

    initial begin
        rst = 1'b1;
        set_req(0, 0, 0, 4'h0, '0, '0);
        set_req(1, 0, 0, 4'h0, '0, '0);
        bus.ctrl_busy = 1'b0; bus.ctrl_out_valid = 1'b0; bus.ctrl_rdata = '0;

        // ---- reset state
        steps(3);
        check_reset("rst");
        rst = 1'b0;
        step();

        // ---- single write, port 0
        chk("t1_idle_civ", bus.ctrl_in_valid, 0);
        set_req(0, 1, 1, 4'hF, 25'h10, 32'hDEADBEEF);
        step();
        chk("t1_civ", bus.ctrl_in_valid, 1);
        chk("t1_rw", bus.ctrl_rw, 1);
        chk("t1_mask", bus.ctrl_mask, 4'hF);
        chk("t1_addr", bus.ctrl_addr, 25'h10);
        chk("t1_wdata", bus.ctrl_wdata, 32'hDEADBEEF);
        chk("t1_gid", bus.grant_id, 0);
        chk("t1_early_ack0", bus.req0_ack, 0);
        step();
        chk("t1_ack0", bus.req0_ack, 1);
        chk("t1_err0", bus.req0_err, 0);
        chk("t1_ack1", bus.req1_ack, 0);
        chk("t1_civ_done", bus.ctrl_in_valid, 0);
        $display("txn port0 write addr=0x10 data=0xdeadbeef");
        bus.req0_valid = 1'b0;
        step();
        chk("t1_ack0_pulse", bus.req0_ack, 0);
        chk("t1_ack1_after", bus.req1_ack, 0);

        // ---- read, port 1, 3 busy cycles, data 5 cycles after acceptance
        set_req(1, 1, 0, 4'hF, 25'h20, '0);
        bus.ctrl_busy = 1'b1;
        step();
        chk("t2_civ", bus.ctrl_in_valid, 1);
        chk("t2_rw", bus.ctrl_rw, 0);
        chk("t2_mask", bus.ctrl_mask, 0);
        chk("t2_addr", bus.ctrl_addr, 25'h20);
        chk("t2_gid", bus.grant_id, 1);
        step();
        chk("t2_hold2", bus.ctrl_in_valid, 1);
        chk("t2_hold2_addr", bus.ctrl_addr, 25'h20);
        step();
        chk("t2_hold3", bus.ctrl_in_valid, 1);
        step();
        bus.ctrl_busy = 1'b0;
        chk("t2_accept_civ", bus.ctrl_in_valid, 1);
        step();
        chk("t2_wait_civ", bus.ctrl_in_valid, 0);
        chk("t2_wait_rw", bus.ctrl_rw, 0);
        steps(4);
        bus.ctrl_out_valid = 1'b1; bus.ctrl_rdata = 32'h12345678;
        step();
        bus.ctrl_out_valid = 1'b0;
        chk("t2_ack1", bus.req1_ack, 1);
        chk("t2_err1", bus.req1_err, 0);
        chk("t2_rdata", bus.rdata, 32'h12345678);
        chk("t2_ack0", bus.req0_ack, 0);
        $display("txn port1 read addr=0x20 data=0x%0h", bus.rdata);
        bus.req1_valid = 1'b0;
        step();
        chk("t2_ack1_pulse", bus.req1_ack, 0);

        // ---- read timeout, port 0
        set_req(0, 1, 0, 4'hF, 25'h30, '0);
        step();
        chk("t4_civ", bus.ctrl_in_valid, 1);
        steps(8);
        chk("t4_early_ack0", bus.req0_ack, 0);
        chk("t4_early_tmo", bus.timeout_err, 0);
        step();
        chk("t4_ack0", bus.req0_ack, 1);
        chk("t4_err0", bus.req0_err, 1);
        chk("t4_tmo", bus.timeout_err, 1);
        chk("t4_rdata_kept", bus.rdata, 32'h12345678);
        $display("txn port0 read addr=0x30 timed out");
        bus.req0_valid = 1'b0;
        step();
        chk("t4_ack0_pulse", bus.req0_ack, 0);
        chk("t4_err0_pulse", bus.req0_err, 0);
        chk("t4_tmo_sticky", bus.timeout_err, 1);

        // ---- next read succeeds
        set_req(1, 1, 0, 4'hF, 25'h40, '0);
        step();
        step();
        bus.ctrl_out_valid = 1'b1; bus.ctrl_rdata = 32'hCAFEF00D;
        step();
        bus.ctrl_out_valid = 1'b0;
        chk("t4b_ack1", bus.req1_ack, 1);
        chk("t4b_err1", bus.req1_err, 0);
        chk("t4b_rdata", bus.rdata, 32'hCAFEF00D);
        chk("t4b_tmo_sticky", bus.timeout_err, 1);
        $display("txn port1 read addr=0x40 data=0x%0h", bus.rdata);
        bus.req1_valid = 1'b0;
        step();

        // ---- stray out_valid in IDLE, then a write keeps rdata
        bus.ctrl_out_valid = 1'b1; bus.ctrl_rdata = 32'hAAAA5555;
        step();
        bus.ctrl_out_valid = 1'b0;
        chk("t5_rdata", bus.rdata, 32'hCAFEF00D);
        chk("t5_ack0", bus.req0_ack, 0);
        chk("t5_ack1", bus.req1_ack, 0);
        chk("t5_civ", bus.ctrl_in_valid, 0);
        step();
        chk("t5_rdata2", bus.rdata, 32'hCAFEF00D);
        chk("t5_ack1b", bus.req1_ack, 0);
        set_req(0, 1, 1, 4'h5, 25'h80, 32'h01020304);
        step();
        chk("t5_w_mask", bus.ctrl_mask, 4'h5);
        step();
        chk("t5_w_ack0", bus.req0_ack, 1);
        chk("t5_w_rdata", bus.rdata, 32'hCAFEF00D);
        $display("txn port0 write addr=0x80 data=0x01020304");
        bus.req0_valid = 1'b0;
        step();

        // ---- out_valid on the timeout cycle: data wins
        set_req(0, 1, 0, 4'hF, 25'h60, '0);
        step();
        steps(8);
        chk("t6_early_ack0", bus.req0_ack, 0);
        bus.ctrl_out_valid = 1'b1; bus.ctrl_rdata = 32'h0BADF00D;
        step();
        bus.ctrl_out_valid = 1'b0;
        chk("t6_ack0", bus.req0_ack, 1);
        chk("t6_err0", bus.req0_err, 0);
        chk("t6_rdata", bus.rdata, 32'h0BADF00D);
        $display("txn port0 read addr=0x60 data=0x%0h", bus.rdata);
        bus.req0_valid = 1'b0;
        step();

        // ---- reset during WAIT_RD
        set_req(1, 1, 0, 4'hF, 25'h70, '0);
        steps(3);
        rst = 1'b1;
        step();
        check_reset("t7");
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t7_no_ack0", bus.req0_ack, 0);
            chk("t7_no_ack1", bus.req1_ack, 0);
        end
        // Requester drops valid while in ISSUE; the write still completes.
        set_req(1, 1, 1, 4'h3, 25'h50, 32'h55AA55AA);
        step();
        chk("t7_w_civ", bus.ctrl_in_valid, 1);
        chk("t7_w_rw", bus.ctrl_rw, 1);
        chk("t7_w_mask", bus.ctrl_mask, 4'h3);
        chk("t7_w_gid", bus.grant_id, 1);
        bus.req1_valid = 1'b0;
        step();
        chk("t7_w_ack1", bus.req1_ack, 1);
        chk("t7_w_err1", bus.req1_err, 0);
        $display("txn port1 write addr=0x50 data=0x55aa55aa");
        step();
        chk("t7_w_ack1_pulse", bus.req1_ack, 0);
        step();
        chk("t7_no_rearb", bus.ctrl_in_valid, 0);

        // ---- both ports continuously, 4 writes each, from reset
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        a0 = 25'h100; a1 = 25'h200;
        set_req(0, 1, 1, 4'hF, a0, 32'h0);
        set_req(1, 1, 1, 4'hF, a1, 32'h1);
        cnt0 = 0; cnt1 = 0; n_acks = 0; last_ack_c = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            exp_port = n_acks % 2;
            chk("t3_no_dual", bus.req0_ack & bus.req1_ack, 0);
            if (bus.ctrl_in_valid)
                chk("t3_issue_addr", bus.ctrl_addr, (exp_port == 0) ? a0 : a1);
            if (bus.req0_ack || bus.req1_ack) begin
                chk("t3_order", bus.req1_ack, exp_port);
                chk("t3_period", c - last_ack_c, (n_acks == 0) ? 2 : 3);
                $display("txn fair port%0d write addr=0x%0h", bus.req1_ack,
                         bus.req1_ack ? a1 : a0);
                last_ack_c = c;
                n_acks++;
                if (bus.req0_ack) begin
                    cnt0++;
                    a0 = a0 + 25'd4;
                    bus.req0_addr = a0;
                    if (cnt0 == 4) bus.req0_valid = 1'b0;
                end else begin
                    cnt1++;
                    a1 = a1 + 25'd4;
                    bus.req1_addr = a1;
                    if (cnt1 == 4) bus.req1_valid = 1'b0;
                end
            end
        end
        chk("t3_cnt0", cnt0, 4);
        chk("t3_cnt1", cnt1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the sdram_controller user interface.
- Lets the Wishbone CPU path (port 0) and a DMA/prefetch engine (port 1) share one controller.
- Serialises requests, one outstanding at a time, and holds the controller handshake stable.
- Returns a single-cycle ack per completed access, with a watchdog on reads.

Parameters:
ADDR_W, 25, controller word address width
DATA_W, 32, data width
RD_TIMEOUT, 1023, max cycles in WAIT_RD before the error completion

Ports:
clk  in  1  system clock (single domain)
rst  in  1  reset, synchronous, active-high
req0_valid / req1_valid  in  1  request pending; held until ack
req0_we / req1_we  in  1  1=write, 0=read
req0_sel / req1_sel  in  4  byte enables
req0_addr / req1_addr  in  ADDR_W  word address
req0_wdata / req1_wdata  in  DATA_W  write data
req0_ack / req1_ack  out  1  one-cycle completion pulse
req0_err / req1_err  out  1  qualifies ack: read timed out
rdata  out  DATA_W  read data; shared by both ports, valid with ackN
ctrl_in_valid  out  1  request to controller
ctrl_rw  out  1  1=write
ctrl_addr  out  ADDR_W  to controller user_addr
ctrl_wdata  out  DATA_W  to controller data_in
ctrl_mask  out  4  byte mask = sel & {4{we}}
ctrl_busy  in  1  controller cannot accept
ctrl_out_valid  in  1  read data valid pulse
ctrl_rdata  in  DATA_W  controller data_out
grant_id  out  1  port currently or last granted
timeout_err  out  1  sticky; set on any read timeout

Behaviour:
- Reset values:
  - state=IDLE; all ack/err=0; rdata=0; ctrl_in_valid=0; ctrl_rw=0; ctrl_addr/wdata/mask=0.
  - last_grant=1, so port 0 wins the first tie; grant_id=0; timeout_err=0.
- IDLE:
  - If any reqN_valid, pick a winner. If both are valid, the port != last_grant wins; if one is valid, it wins.
  - Latch winner id, we, sel, addr, wdata into internal registers; go to ISSUE.
- ISSUE:
  - ctrl_in_valid=1; ctrl_rw/addr/wdata/mask are driven from the latched registers and stay stable.
  - Acceptance is the cycle with ~ctrl_busy. Write accepted -> RESP. Read accepted -> WAIT_RD, clear timer.
  - If ctrl_busy, stay in ISSUE with the request held.
- WAIT_RD:
  - ctrl_in_valid=0, ctrl_rw=0; timer increments each cycle.
  - ctrl_out_valid: rdata<=ctrl_rdata -> RESP.
  - Timer==RD_TIMEOUT without out_valid: err flag set, timeout_err<=1, rdata unchanged -> RESP.
  - out_valid and timeout in the same cycle: data wins, no error.
- RESP:
  - ackN=1 (and errN if flagged) for the latched id only, exactly one cycle.
  - last_grant<=id -> IDLE. A new arbitration occurs no earlier than the following IDLE cycle.
- Latency:
  - Write: valid sampled in IDLE at T, accepted at T+1 if not busy, ack at T+2. Each busy cycle adds 1.
  - Read: ack one cycle after ctrl_out_valid.
  - Back-to-back minimum period: 3 cycles per write.
- Edge cases:
  - ctrl_out_valid outside WAIT_RD is ignored (no state or rdata change).
  - Requester dropping valid before ack: the transaction still completes and the ack is still pulsed; it is the requester's fault.
  - Losing port keeps waiting; fairness guarantees service within one other transaction.
  - rdata holds its value across write acks.
  - rst mid-transaction aborts to IDLE with no ack; the controller shares rst.
- grant_id updates when a request is latched in IDLE.

Decomposition:
- Package sdram_arb_pkg: state encoding (IDLE, ISSUE, WAIT_RD, RESP), default ADDR_W/DATA_W constants, mask helper.
- Natural sub-module: rr_pick2, a combinational two-input round-robin selector (valid0, valid1, last -> gnt, any).
- The FSM, latch registers and timer stay in the top.

Test Plan:
- Single write, port 0, addr=0x000010, wdata=0xDEADBEEF, sel=0xF, busy=0:
  - ctrl_in_valid high exactly at T+1 with ctrl_rw=1, ctrl_mask=0xF.
  - req0_ack at T+2; req1_ack never.
- Read, port 1, addr=0x000020; controller busy for 3 cycles, then out_valid after 5 cycles with 0x12345678:
  - ctrl_in_valid is held through busy; rdata=0x12345678 with req1_ack, err=0.
- Both valid continuously, 4 writes each, from reset:
  - Grant order is 0,1,0,1,...; ack counts 4/4.
  - Each ack is 1 cycle; no two acks in the same cycle.
- Read with no out_valid, RD_TIMEOUT=8:
  - reqN_ack and reqN_err at acceptance+9; timeout_err stays 1.
  - Next read succeeds with err=0.
- Stray ctrl_out_valid in IDLE with ctrl_rdata=0xAAAA5555:
  - rdata unchanged, no ack.
- Same-cycle out_valid and timeout: the data is delivered and err=0.
- rst asserted during WAIT_RD:
  - Next cycle all outputs are at reset values and no ack is issued.
  - A subsequent write completes normally.
